// File: rtl/simon_sequencer.sv
// simon_sequencer: four-colour memory game controller.
// Grows a pseudo-random colour sequence, plays it back one colour at a time
// for a programmable number of frame ticks, then checks player presses.
// Every output is registered alongside the state, so an output reflects the
// state entered on the same clock edge.
module simon_sequencer #(
    parameter int          MAX_LEN        = 31,
    parameter int          ON_FRAMES      = 30,
    parameter int          OFF_FRAMES     = 15,
    parameter int          TIMEOUT_FRAMES = 300,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [3:0] btn,
    output logic       red_flag,
    output logic       green_flag,
    output logic       blue_flag,
    output logic       yellow_flag,
    output logic [4:0] level,
    output logic       game_over,
    output logic       game_won,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADD,
        S_PRE,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_INPUT,
        S_FEEDBACK,
        S_FAIL,
        S_WIN
    } state_t;

    // Last frame-count value of each timed state (exit when a tick lands on it)
    localparam logic [15:0] ON_LAST  = 16'(ON_FRAMES - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_FRAMES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_FRAMES - 1);
    localparam logic        TO_EN    = (TIMEOUT_FRAMES != 0);
    localparam logic [4:0]  WIN_LEN  = 5'(MAX_LEN);

    // Registered state
    state_t      r_state;
    logic [4:0]  r_len;
    logic [4:0]  r_idx;
    logic [15:0] r_fcnt;
    logic [15:0] r_lfsr;
    logic [1:0]  r_col;
    logic [1:0]  r_seq [0:31];
    logic [3:0]  r_flags;
    logic        r_game_over;
    logic        r_game_won;
    logic        r_busy;

    // Next-state and decode signals
    state_t      w_state_next;
    logic [4:0]  w_len_next;
    logic [4:0]  w_idx_next;
    logic [15:0] w_fcnt_next;
    logic [1:0]  w_col_next;
    logic        w_seq_we;
    logic        w_lfsr_fb;
    logic [1:0]  w_cur_col;
    logic [3:0]  w_cur_onehot;
    logic        w_btn_ok;
    logic        w_last;
    logic        w_timed;
    logic        w_on_done;
    logic        w_off_done;
    logic        w_to_done;
    logic [1:0]  w_show_col;
    logic [1:0]  w_flag_col;
    logic        w_flag_en;
    logic [3:0]  w_flags_next;

    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cur_col  = r_seq[r_idx];
    assign w_last     = (r_idx == 5'(r_len - 5'd1));
    assign w_on_done  = frame_tick && (r_fcnt == ON_LAST);
    assign w_off_done = frame_tick && (r_fcnt == OFF_LAST);
    assign w_to_done  = TO_EN && frame_tick && (r_fcnt == TO_LAST);
    assign w_timed    = (r_state == S_PRE) || (r_state == S_SHOW_ON) ||
                        (r_state == S_SHOW_OFF) || (r_state == S_WAIT_INPUT) ||
                        (r_state == S_FEEDBACK);

    // A press is correct only when it is exactly the one-hot code of the
    // expected colour; multi-bit presses therefore never match.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cur_dec
            assign w_cur_onehot[gi] = (w_cur_col == 2'(gi));
        end
    endgenerate
    assign w_btn_ok = (btn == w_cur_onehot);

    // Next-state decision for the game FSM
    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_idx_next   = r_idx;
        w_col_next   = r_col;
        w_seq_we     = 1'b0;
        case (r_state)
            S_IDLE, S_FAIL, S_WIN: begin
                if (start) begin
                    w_state_next = S_ADD;
                    w_len_next   = 5'd0;
                end
            end
            S_ADD: begin
                w_seq_we     = 1'b1;
                w_len_next   = r_len + 5'd1;
                w_state_next = S_PRE;
            end
            S_PRE: begin
                if (w_off_done) begin
                    w_state_next = S_SHOW_ON;
                    w_idx_next   = 5'd0;
                end
            end
            S_SHOW_ON: begin
                if (w_on_done) begin
                    w_state_next = S_SHOW_OFF;
                end
            end
            S_SHOW_OFF: begin
                if (w_off_done) begin
                    if (w_last) begin
                        w_state_next = S_WAIT_INPUT;
                        w_idx_next   = 5'd0;
                    end else begin
                        w_state_next = S_SHOW_ON;
                        w_idx_next   = r_idx + 5'd1;
                    end
                end
            end
            S_WAIT_INPUT: begin
                // A press wins over a timeout landing on the same tick
                if (btn != 4'd0) begin
                    if (w_btn_ok) begin
                        w_state_next = S_FEEDBACK;
                        w_col_next   = w_cur_col;
                    end else begin
                        w_state_next = S_FAIL;
                    end
                end else if (w_to_done) begin
                    w_state_next = S_FAIL;
                end
            end
            S_FEEDBACK: begin
                if (w_on_done) begin
                    if (!w_last) begin
                        w_state_next = S_WAIT_INPUT;
                        w_idx_next   = r_idx + 5'd1;
                    end else if (r_len == WIN_LEN) begin
                        w_state_next = S_WIN;
                    end else begin
                        w_state_next = S_ADD;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Frame counter restarts on every state change, so each timed state
    // (including FEEDBACK back to WAIT_INPUT) begins counting from zero.
    always_comb begin
        w_fcnt_next = r_fcnt;
        if ((w_state_next != r_state) || !w_timed) begin
            w_fcnt_next = 16'd0;
        end else if (frame_tick) begin
            w_fcnt_next = r_fcnt + 16'd1;
        end
    end

    // Flag decode for the state being entered: playback colour or pressed colour
    assign w_show_col = r_seq[w_idx_next];
    assign w_flag_col = (w_state_next == S_FEEDBACK) ? w_col_next : w_show_col;
    assign w_flag_en  = (w_state_next == S_SHOW_ON) || (w_state_next == S_FEEDBACK);
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_flag_dec
            assign w_flags_next[gi] = w_flag_en && (w_flag_col == 2'(gi));
        end
    endgenerate

    // State, counters, LFSR and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= 5'd0;
            r_idx       <= 5'd0;
            r_fcnt      <= 16'd0;
            r_lfsr      <= LFSR_SEED;
            r_col       <= 2'd0;
            r_flags     <= 4'd0;
            r_game_over <= 1'b0;
            r_game_won  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_len       <= w_len_next;
            r_idx       <= w_idx_next;
            r_fcnt      <= w_fcnt_next;
            r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
            r_col       <= w_col_next;
            r_flags     <= w_flags_next;
            r_game_over <= (w_state_next == S_FAIL);
            r_game_won  <= (w_state_next == S_WIN);
            r_busy      <= (w_state_next != S_IDLE) && (w_state_next != S_FAIL) &&
                           (w_state_next != S_WIN);
        end
    end

    // Sequence storage: each entry captures the LFSR colour when ADD targets it.
    // Entries are not reset; anything at or above len is never read.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_seq
            always_ff @(posedge clk) begin
                if (!reset && w_seq_we && (r_len == 5'(gi))) begin
                    r_seq[gi] <= r_lfsr[1:0];
                end
            end
        end
    endgenerate

    assign red_flag    = r_flags[0];
    assign green_flag  = r_flags[1];
    assign blue_flag   = r_flags[2];
    assign yellow_flag = r_flags[3];
    assign level       = r_len;
    assign game_over   = r_game_over;
    assign game_won    = r_game_won;
    assign busy        = r_busy;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed testbench for simon_sequencer with a small game settings set.
module tb_simon_sequencer;

    localparam int          MAX_LEN = 2;
    localparam int          ON      = 2;
    localparam int          OFF     = 1;
    localparam int          TMO     = 4;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic       frame_tick;
    logic       red_flag, green_flag, blue_flag, yellow_flag;
    logic [4:0] level;
    logic       game_over, game_won, busy;

    int vecs = 0;
    int errs = 0;

    logic [1:0]  cols [0:3];
    logic [15:0] m_lfsr;
    int unsigned cyc = 0;
    wire  [3:0]  flags = {yellow_flag, blue_flag, green_flag, red_flag};

    simon_sequencer #(
        .MAX_LEN(MAX_LEN), .ON_FRAMES(ON), .OFF_FRAMES(OFF),
        .TIMEOUT_FRAMES(TMO), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .btn(btn),
        .red_flag(red_flag), .green_flag(green_flag), .blue_flag(blue_flag),
        .yellow_flag(yellow_flag), .level(level), .game_over(game_over),
        .game_won(game_won), .busy(busy)
    );

    always #5 clk = ~clk;

    // Free-running frame tick: one pulse every 8 cycles
    always @(posedge clk) cyc <= cyc + 1;
    assign frame_tick = ((cyc % 8) == 7);

    // Reference LFSR, x^16+x^14+x^13+x^11+1, shifting left every non-reset cycle
    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        oh = 4'b0001 << c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        step();
        btn = 4'd0;
    endtask

    // Observe one timed segment: flags constant and busy high until n ticks pass
    task automatic run_segment(input string name, input logic [3:0] exp_flags, input int n);
        int cnt;
        int guard;
        cnt = 0;
        guard = 0;
        while (cnt < n && guard < 100) begin
            vecs++;
            if (flags !== exp_flags || busy !== 1'b1) begin
                errs++;
                $display("FAIL %s: flags=%b busy=%b, expected flags=%b busy=1",
                         name, flags, busy, exp_flags);
            end
            if (frame_tick) cnt++;
            step();
            guard++;
        end
        vecs++;
        if (cnt !== n) begin
            errs++;
            $display("FAIL %s_ticks: saw %0d ticks, expected %0d", name, cnt, n);
        end
    endtask

    // In the ADD cycle: capture the reference colour, then check level grows
    task automatic do_add(input int lvl);
        vecs++;
        if (busy !== 1'b1 || flags !== 4'd0 || level !== 5'(lvl - 1)) begin
            errs++;
            $display("FAIL add_cycle: busy=%b flags=%b level=%0d, expected 1 0000 %0d",
                     busy, flags, level, lvl - 1);
        end
        cols[lvl - 1] = m_lfsr[1:0];
        step();
        vecs++;
        if (level !== 5'(lvl)) begin
            errs++;
            $display("FAIL add_level: level=%0d, expected %0d", level, lvl);
        end
    endtask

    task automatic play(input int len);
        run_segment("pre", 4'd0, OFF);
        for (int i = 0; i < len; i++) begin
            run_segment("show_on", oh(cols[i]), ON);
            run_segment("show_off", 4'd0, OFF);
        end
    endtask

    task automatic new_game();
        start = 1'b1;
        step();
        start = 1'b0;
        do_add(1);
        play(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'd0;
        step();
        step();
        vecs++;
        if ({flags, level, game_over, game_won, busy} !== 12'd0) begin
            errs++;
            $display("FAIL reset_outputs: %b, expected all zero",
                     {flags, level, game_over, game_won, busy});
        end
        reset = 1'b0;
        press(4'b0100);
        vecs++;
        if ({flags, level, game_over, game_won, busy} !== 12'd0) begin
            errs++;
            $display("FAIL idle_hold: %b, expected all zero",
                     {flags, level, game_over, game_won, busy});
        end
    endtask

    task automatic test_first_round();
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL start_busy: busy=%b, expected 1", busy);
        end
        do_add(1);
        play(1);
        vecs++;
        if (flags !== 4'd0 || busy !== 1'b1 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL wait_entry: flags=%b busy=%b over=%b, expected 0000 1 0",
                     flags, busy, game_over);
        end
    endtask

    task automatic test_correct_press();
        press(oh(cols[0]));
        vecs++;
        if (flags !== oh(cols[0])) begin
            errs++;
            $display("FAIL press_latency: flags=%b, expected %b", flags, oh(cols[0]));
        end
        run_segment("feedback", oh(cols[0]), ON);
        do_add(2);
        play(2);
    endtask

    task automatic test_win();
        for (int i = 0; i < 2; i++) begin
            press(oh(cols[i]));
            vecs++;
            if (flags !== oh(cols[i]) || game_over !== 1'b0) begin
                errs++;
                $display("FAIL press_%0d: flags=%b over=%b, expected %b 0",
                         i, flags, game_over, oh(cols[i]));
            end
            run_segment("feedback", oh(cols[i]), ON);
        end
        vecs++;
        if (game_won !== 1'b1 || busy !== 1'b0 || flags !== 4'd0 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL win_state: won=%b busy=%b flags=%b over=%b, expected 1 0 0000 0",
                     game_won, busy, flags, game_over);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if (game_won !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL win_restart: won=%b busy=%b, expected 0 1", game_won, busy);
        end
        do_add(1);
    endtask

    task automatic test_wrong_press();
        logic [1:0] wrong;
        play(1);
        wrong = cols[0] + 2'd1;
        press(oh(wrong));
        vecs++;
        if (game_over !== 1'b1 || flags !== 4'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL wrong_colour: over=%b flags=%b busy=%b, expected 1 0000 0",
                     game_over, flags, busy);
        end
        press(oh(cols[0]));
        vecs++;
        if (game_over !== 1'b1 || flags !== 4'd0 || level !== 5'd1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL btn_in_fail: over=%b flags=%b level=%0d busy=%b, expected 1 0000 1 0",
                     game_over, flags, level, busy);
        end
        new_game();
        press(4'b0011);
        vecs++;
        if (game_over !== 1'b1 || flags !== 4'd0) begin
            errs++;
            $display("FAIL multi_bit: over=%b flags=%b, expected 1 0000", game_over, flags);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        int guard;
        new_game();
        cnt = 0;
        guard = 0;
        while (cnt < TMO && guard < 100) begin
            vecs++;
            if (game_over !== 1'b0 || busy !== 1'b1) begin
                errs++;
                $display("FAIL timeout_early: over=%b busy=%b, expected 0 1", game_over, busy);
            end
            if (frame_tick) cnt++;
            step();
            guard++;
        end
        vecs++;
        if (game_over !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL timeout_fail: over=%b busy=%b, expected 1 0", game_over, busy);
        end
        // Correct press on the same edge as the timeout-completing tick
        new_game();
        cnt = 0;
        guard = 0;
        while (guard < 100) begin
            if (frame_tick && cnt == TMO - 1) break;
            if (frame_tick) cnt++;
            step();
            guard++;
        end
        press(oh(cols[0]));
        vecs++;
        if (flags !== oh(cols[0]) || game_over !== 1'b0) begin
            errs++;
            $display("FAIL press_vs_timeout: flags=%b over=%b, expected %b 0",
                     flags, game_over, oh(cols[0]));
        end
        run_segment("feedback", oh(cols[0]), ON);
        do_add(2);
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        do_add(1);
        run_segment("pre", 4'd0, OFF);
        // Start and button pulses while the colour is showing must be ignored
        start = 1'b1;
        btn   = oh(cols[0]);
        step();
        start = 1'b0;
        btn   = 4'd0;
        vecs++;
        if (flags !== oh(cols[0]) || busy !== 1'b1 || level !== 5'd1 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL show_ignore: flags=%b busy=%b level=%0d over=%b, expected %b 1 1 0",
                     flags, busy, level, game_over, oh(cols[0]));
        end
        reset = 1'b1;
        step();
        vecs++;
        if ({flags, level, game_over, game_won, busy} !== 12'd0) begin
            errs++;
            $display("FAIL mid_reset: %b, expected all zero",
                     {flags, level, game_over, game_won, busy});
        end
        reset = 1'b0;
        step();
        vecs++;
        if ({flags, level, game_over, game_won, busy} !== 12'd0) begin
            errs++;
            $display("FAIL post_reset_idle: %b, expected all zero",
                     {flags, level, game_over, game_won, busy});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL restart_busy: busy=%b, expected 1", busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'd0;
        test_reset();
        test_first_round();
        test_correct_press();
        test_win();
        test_wrong_press();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
